// File: rtl/tpu_host_driver.sv
// Host-side initiator for the 2x2 TPU pin protocol: loads eight operand bytes,
// issues compute, waits for done, gathers eight result bytes and returns them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | job_ready high, waiting for a job
// ST_LOAD  | driving operand byte idx with OP_LOAD
// ST_START | one OP_COMPUTE cycle, arms the done timeout
// ST_WAIT  | OP_NOP, waiting for done or timeout
// ST_READ  | capturing result bytes 1..7, one per cycle
// ST_RESP  | res_valid held until the consumer takes it
module tpu_host_driver #(
  parameter logic [2:0] OP_NOP         = 3'b000,
  parameter logic [2:0] OP_LOAD        = 3'b001,
  parameter logic [2:0] OP_COMPUTE     = 3'b010,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  // The START cycle counts as the first of the budget, so WAIT gets TIMEOUT_CYCLES-1
  // cycles; the counter terminates at zero on the last of them.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [2:0]       state;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0][7:0]  shadow;
  logic             done;
  logic             unused_uio;

  assign idx_nxt    = idx + 3'd1;
  assign done       = tpu_uio_out[7];
  assign unused_uio = ^tpu_uio_out[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      wait_cnt    <= '0;
      shadow      <= '0;
      job_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
      res_data    <= 64'd0;
      busy        <= 1'b0;
      tpu_ui_in   <= 8'd0;
      tpu_uio_in  <= {5'b0, OP_NOP};
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_valid && job_ready) begin
            shadow     <= job_data;
            idx        <= 3'd0;
            tpu_ui_in  <= job_data[7:0];
            tpu_uio_in <= {5'b0, OP_LOAD};
            job_ready  <= 1'b0;
            busy       <= 1'b1;
            res_data   <= 64'd0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (idx == 3'd7) begin
            tpu_ui_in  <= 8'd0;
            tpu_uio_in <= {5'b0, OP_COMPUTE};
            state      <= ST_START;
          end else begin
            idx       <= idx_nxt;
            tpu_ui_in <= shadow[idx_nxt];
          end
        end
        ST_START: begin
          tpu_uio_in <= {5'b0, OP_NOP};
          wait_cnt   <= CNT_LOAD;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            res_data[7:0] <= tpu_uo_out;
            idx           <= 3'd1;
            state         <= ST_READ;
          end else if (wait_cnt == '0) begin
            res_timeout <= 1'b1;
            res_data    <= 64'd0;
            res_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_READ: begin
          // Byte i lands at bits [8i+7:8i]: C00lo, C00hi, C01lo, ... C11hi.
          res_data[{idx, 3'b000} +: 8] <= tpu_uo_out;
          if (idx == 3'd7) begin
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            idx <= idx_nxt;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// Bench for tpu_host_driver: a pin-level TPU model plus a cycle-offset model of the
// driver's outputs, checked every cycle, and literal expectations per job.
module tb_tpu_host_driver;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_COMPUTE = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] job_data = 64'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_timeout;
  logic        busy;
  logic [7:0]  tpu_ui_in;
  logic [7:0]  tpu_uio_in;
  logic [7:0]  tpu_uo_out = 8'd0;
  logic [7:0]  tpu_uio_out;
  logic        tpu_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // TPU model configuration: done arrives tpu_d cycles after OP_COMPUTE (0 = never)
  int         tpu_d = 0;
  bit         tpu_early = 1'b0;
  logic [7:0] tpu_stream [8];
  int         start_cyc = -1000;
  int         n_compute = 0;
  logic [7:0] load_q [$];

  // Driver model state
  bit          m_active = 1'b0;
  int          m_off = 0;
  int          m_len = 0;
  bit          m_to = 1'b0;
  logic [63:0] m_job = 64'd0;
  logic [63:0] m_exp = 64'd0;
  bit          e_load, e_comp, e_resp;

  assign tpu_uio_out = {tpu_done, 7'h55};

  tpu_host_driver #(
    .OP_NOP(OP_NOP), .OP_LOAD(OP_LOAD), .OP_COMPUTE(OP_COMPUTE), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy),
    .tpu_ui_in(tpu_ui_in), .tpu_uio_in(tpu_uio_in),
    .tpu_uo_out(tpu_uo_out), .tpu_uio_out(tpu_uio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TPU pin model: logs load bytes, answers OP_COMPUTE with done plus an 8-byte stream
  initial begin
    int k;
    forever begin
      @(posedge clk); #1;
      if (tpu_uio_in[2:0] == OP_COMPUTE) begin
        start_cyc = cyc;
        n_compute++;
      end
      if (tpu_uio_in[2:0] == OP_LOAD) load_q.push_back(tpu_ui_in);
      k = cyc - start_cyc - tpu_d;
      if (tpu_d > 0 && k >= 0 && k < 8) begin
        tpu_done   = 1'b1;
        tpu_uo_out = tpu_stream[k];
      end else if (tpu_d > 0 && tpu_early && k == -1) begin
        tpu_done   = 1'b1;
        tpu_uo_out = 8'hEE;
      end else begin
        tpu_done   = 1'b0;
        tpu_uo_out = 8'h5A;
      end
    end
  end

  // Offset schedule from the accept cycle: 1..8 load, 9 compute, then wait/read, then response
  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_timeout", 64'(res_timeout), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_ui", 64'(tpu_ui_in), 64'd0);
        chk("rst_uio", 64'(tpu_uio_in), 64'({5'b0, OP_NOP}));
        m_active = 1'b0;
      end else if (!m_active) begin
        chk("idle_job_ready", 64'(job_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_res_valid", 64'(res_valid), 64'd0);
        chk("idle_res_timeout", 64'(res_timeout), 64'd0);
        chk("idle_ui", 64'(tpu_ui_in), 64'd0);
        chk("idle_uio", 64'(tpu_uio_in), 64'({5'b0, OP_NOP}));
        if (job_valid) begin
          m_active = 1'b1;
          m_off    = 1;
          m_job    = job_data;
          m_to     = (tpu_d == 0);
          m_len    = (tpu_d > 0) ? tpu_d + 7 : 63;
          m_exp    = 64'd0;
          if (tpu_d > 0)
            for (int i = 0; i < 4; i++) m_exp[16*i +: 16] = {tpu_stream[2*i+1], tpu_stream[2*i]};
        end
      end else begin
        e_load = (m_off >= 1 && m_off <= 8);
        e_comp = (m_off == 9);
        e_resp = (m_off >= 10 + m_len);
        chk("job_ready", 64'(job_ready), 64'd0);
        chk("busy", 64'(busy), 64'd1);
        chk("res_valid", 64'(res_valid), 64'(e_resp));
        chk("res_timeout", 64'(res_timeout), 64'(e_resp && m_to));
        chk("tpu_ui_in", 64'(tpu_ui_in), e_load ? 64'(m_job[8*(m_off-1) +: 8]) : 64'd0);
        chk("tpu_uio_in", 64'(tpu_uio_in),
            64'({5'b0, e_load ? OP_LOAD : (e_comp ? OP_COMPUTE : OP_NOP)}));
        if (e_resp) chk("res_data", res_data, m_exp);
        if (e_resp && res_ready) m_active = 1'b0;
        else m_off++;
      end
    end
  end

  task automatic offer_job(input logic [63:0] jd);
    int n = 0;
    while (job_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("job_ready_wait_bound", 64'(n < 50), 64'd1);
    job_data  = jd;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_data  = ~jd;
  endtask

  task automatic run_job(input logic [63:0] jd, input int hold, input bit pulse,
                         input logic [63:0] exp_data, input bit exp_to, input int exp_lat);
    int n = 0;
    offer_job(jd);
    while (res_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("res_wait_bound", 64'(n < 300), 64'd1);
    chk("res_data_lit", res_data, exp_data);
    chk("res_timeout_lit", 64'(res_timeout), 64'(exp_to));
    chk("latency_from_start", 64'(cyc - start_cyc), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      job_valid = pulse & i[0];
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    if (hold > 0) begin
      chk("held_res_valid", 64'(res_valid), 64'd1);
      chk("held_res_data", res_data, exp_data);
      chk("held_job_ready", 64'(job_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("job_ready_after_hs", 64'(job_ready), 64'd1);
    chk("res_valid_after_hs", 64'(res_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Basic job: W=[1,2;3,4], X=[5,6;7,8]
    tpu_d = 5; tpu_early = 1'b0;
    tpu_stream = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
    load_q.delete(); n_compute = 0;
    run_job(64'h0807_0605_0403_0201, 0, 1'b0, 64'h0032_002B_0016_0013, 1'b0, 13);
    chk("basic_load_count", 64'(load_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < load_q.size(); i++)
      chk("basic_load_byte", 64'(load_q[i]), 64'(i + 1));
    chk("basic_compute_count", 64'(n_compute), 64'd1);

    // Wide unsigned results
    tpu_d = 3;
    tpu_stream = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h01, 8'h00, 8'hFF, 8'hFF};
    run_job(64'h1122_3344_5566_7788, 0, 1'b0, 64'hFFFF_0001_8000_7FFF, 1'b0, 11);

    // Timeout: done never arrives
    tpu_d = 0;
    run_job(64'hDEAD_BEEF_0BAD_F00D, 0, 1'b0, 64'd0, 1'b1, 64);

    // Normal job after a timeout
    tpu_d = 2;
    tpu_stream = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
    run_job(64'h0807_0605_0403_0201, 0, 1'b0, 64'h0032_002B_0016_0013, 1'b0, 10);

    // Backpressure with ignored job_valid pulses
    tpu_d = 4;
    tpu_stream = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h01, 8'h00, 8'hFF, 8'hFF};
    run_job(64'h0102_0304_0506_0708, 20, 1'b1, 64'hFFFF_0001_8000_7FFF, 1'b0, 12);

    // Reset in the cycle that shows load byte 3
    tpu_d = 1;
    offer_job(64'hA7A6_A5A4_A3A2_A1A0);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_load_byte3", 64'(tpu_ui_in), 64'hA3);
    chk("mid_load_op", 64'(tpu_uio_in), 64'({5'b0, OP_LOAD}));
    rst = 1'b1;
    #2;
    chk("async_rst_job_ready", 64'(job_ready), 64'd1);
    chk("async_rst_uio", 64'(tpu_uio_in), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh job after reset, with done already high during START and in the first WAIT cycle
    tpu_d = 1; tpu_early = 1'b1;
    tpu_stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    load_q.delete();
    run_job(64'hC7C6_C5C4_C3C2_C1C0, 0, 1'b0, 64'h8877_6655_4433_2211, 1'b0, 9);
    chk("fresh_load_count", 64'(load_q.size()), 64'd8);
    if (load_q.size() == 8) begin
      chk("fresh_load_first", 64'(load_q[0]), 64'hC0);
      chk("fresh_load_last", 64'(load_q[7]), 64'hC7);
    end
    tpu_early = 1'b0;

    repeat (3) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
